multi_main_control: RTL and testbench

Main control state machine for the multi-cycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back steps from the 6-bit opcode, and drives every datapath enable and mux select. Its `aluop` output feeds the existing ALU-control decoder. Memory accesses use a ready handshake, so the controller stalls on slow memory.

---
 rtl/multi_main_control_pkg.sv | 39 +++
 rtl/multi_ctrl_decode.sv | 71 +++++++
 rtl/multi_main_control.sv | 74 +++++++
 tb/tb_multi_main_control.sv | 114 +++++++++++
 4 files changed

// File: rtl/multi_main_control_pkg.sv
// multi_main_control_pkg: state, opcode and select encodings plus the control vector for the multi-cycle MIPS controller
package multi_main_control_pkg;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
  } state_e;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00;
  localparam logic [1:0] SRCB_4 = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       retire;
  } ctrl_t;
endpackage

// File: rtl/multi_ctrl_decode.sv
// multi_ctrl_decode: combinational map from (state, mem_ready) to the control vector; ADDI states live only under MULTI_ADDI_EN
module multi_ctrl_decode
  import multi_main_control_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_4;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      DECODE: ctrl.alusrcb = SRCB_SHIMM;
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.iord = 1'b1;
        ctrl.memread = 1'b1;
      end
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.retire = 1'b1;
      end
      MEMWR: begin
        ctrl.iord = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.retire = mem_ready;
      end
      EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.retire = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsrc = PCSRC_ALUOUT;
        ctrl.retire = 1'b1;
      end
      JUMP: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc = PCSRC_JUMP;
        ctrl.retire = 1'b1;
      end
`ifdef MULTI_ADDI_EN
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.retire = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multi_main_control.sv
// multi_main_control: multi-cycle MIPS main controller (state register, next-state, retire counter, reset forcing); MULTI_ADDI_EN enables addi
module multi_main_control
  import multi_main_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             illegal_op,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] count_q;
  ctrl_t dec, ctrl;
  logic known;
  multi_ctrl_decode u_dec (.state(state_q), .mem_ready(mem_ready), .ctrl(dec));
`ifdef MULTI_ADDI_EN
  assign known = opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI};
`else
  assign known = opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J};
`endif
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                        opcode == OP_RTYPE ? EXEC :
                        opcode == OP_BEQ ? BRANCH :
                        opcode == OP_J ? JUMP :
`ifdef MULTI_ADDI_EN
                        opcode == OP_ADDI ? ADDIEX :
`endif
                        FETCH;
      MEMADR: state_d = opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
`ifdef MULTI_ADDI_EN
      ADDIEX: state_d = ADDIWB;
`endif
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= !reset_n ? FETCH : state_d;
    count_q <= !reset_n ? '0 : count_q + CNT_W'(dec.retire);
  end
  assign ctrl = reset_n ? dec : '0;
  assign illegal_op = reset_n && state_q == DECODE && !known;
  assign {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
          alusrca, alusrcb, aluop, pcsrc, retire} = ctrl;
  assign instr_count = count_q;
  assign state = state_q;
  logic unused;
  assign unused = zero;
endmodule

// File: tb/tb_multi_main_control.sv
// tb_multi_main_control: directed checks of the multi-cycle controller sequencing, stalls, illegal ops, reset and addi
module tb_multi_main_control;
  logic clk = 0, reset_n = 0, zero = 0, mem_ready = 1;
  logic [5:0] opcode = 6'b0;
  logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
  logic illegal_op, retire;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [31:0] instr_count;
  logic [3:0] state;
  int tests = 0, fails = 0;
  multi_main_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .illegal_op(illegal_op), .retire(retire), .instr_count(instr_count), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst_state", 32'(state), 0);
    chk("rst_count", instr_count, 0);
    chk("rst_memread", 32'(memread), 0);
    chk("rst_alusrcb", 32'(alusrcb), 0);
    chk("rst_irwrite", 32'(irwrite), 0);
    reset_n = 1;
    opcode = 6'b100011;
    #1;
    chk("lw_f_memread", 32'(memread), 1);
    chk("lw_f_irwrite", 32'(irwrite), 1);
    chk("lw_f_pcwrite", 32'(pcwrite), 1);
    chk("lw_f_alusrcb", 32'(alusrcb), 1);
    step(); chk("lw_s1", 32'(state), 1); chk("lw_d_alusrcb", 32'(alusrcb), 3);
    step(); chk("lw_s2", 32'(state), 2); chk("lw_a_srcs", {alusrca, alusrcb}, 3'b110);
    step(); chk("lw_s3", 32'(state), 3); chk("lw_rd", {iord, memread}, 2'b11);
    step(); chk("lw_s4", 32'(state), 4); chk("lw_wb", {memtoreg, regwrite, retire}, 3'b111);
    step(); chk("lw_s0", 32'(state), 0); chk("lw_count", instr_count, 1);
    opcode = 6'b101011;
    step(); chk("sw_s1", 32'(state), 1);
    step(); chk("sw_s2", 32'(state), 2);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("sw_stall_state", 32'(state), 5);
      chk("sw_stall_wr", {memwrite, iord, retire}, 3'b110);
    end
    mem_ready = 1;
    #1;
    chk("sw_ready_wr", {memwrite, retire}, 2'b11);
    step(); chk("sw_s0", 32'(state), 0); chk("sw_count", instr_count, 2);
    mem_ready = 0;
    #1;
    chk("fetch_stall_ir", {memread, irwrite, pcwrite}, 3'b100);
    step(); chk("fetch_stall_state", 32'(state), 0);
    mem_ready = 1;
    opcode = 6'b000100;
    step(); chk("beq_s1", 32'(state), 1);
    step(); chk("beq_s8", 32'(state), 8);
    chk("beq_ctl", {aluop, pcwritecond, pcsrc, retire, alusrca}, 7'b01_1_01_1_1);
    step(); chk("beq_s0", 32'(state), 0); chk("beq_count", instr_count, 3);
    opcode = 6'b111111;
    step(); chk("ill_s1", 32'(state), 1); chk("ill_pulse", 32'(illegal_op), 1);
    step(); chk("ill_s0", 32'(state), 0); chk("ill_low", 32'(illegal_op), 0);
    chk("ill_count", instr_count, 3);
    opcode = 6'b000000;
    step(); chk("r_s1", 32'(state), 1); chk("r_legal", 32'(illegal_op), 0);
    step(); chk("r_s6", 32'(state), 6); chk("r_aluop", 32'(aluop), 2);
    reset_n = 0;
    #1;
    chk("rst_mid_forced", {aluop, alusrca, regwrite, retire}, 0);
    step(); chk("rst_mid_state", 32'(state), 0);
    chk("rst_mid_regwrite", 32'(regwrite), 0);
    chk("rst_mid_count", instr_count, 0);
    reset_n = 1;
    opcode = 6'b000010;
    step(); chk("j_s1", 32'(state), 1);
    step(); chk("j_s9", 32'(state), 9); chk("j_ctl", {pcwrite, pcsrc, retire}, 4'b1_10_1);
    step(); chk("j_s0", 32'(state), 0); chk("j_count", instr_count, 1);
    opcode = 6'b001000;
    step(); chk("addi_s1", 32'(state), 1);
`ifdef MULTI_ADDI_EN
    chk("addi_legal", 32'(illegal_op), 0);
    step(); chk("addi_s10", 32'(state), 10); chk("addi_ex", {alusrca, alusrcb}, 3'b110);
    step(); chk("addi_s11", 32'(state), 11); chk("addi_wb", {regwrite, retire}, 2'b11);
    step(); chk("addi_s0", 32'(state), 0); chk("addi_count", instr_count, 2);
`else
    chk("addi_illegal", 32'(illegal_op), 1);
    step(); chk("addi_s0", 32'(state), 0); chk("addi_count", instr_count, 1);
`endif
    opcode = 6'b000000;
    step(); chk("r2_s1", 32'(state), 1);
    step(); chk("r2_s6", 32'(state), 6);
    step(); chk("r2_s7", 32'(state), 7); chk("r2_wb", {regdst, regwrite, retire}, 3'b111);
    step(); chk("r2_s0", 32'(state), 0);
`ifdef MULTI_ADDI_EN
    chk("r2_count", instr_count, 3);
`else
    chk("r2_count", instr_count, 2);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
